// File: rtl/dma_2d_pkg.sv
// Shared definitions for the 2D DMA read and write masters.
//   dma_state_t      one-hot master state encoding (IDLE/ADDR/DATA/RESP)
//   BURST_INCR       AXI AxBURST value for incrementing bursts
//   SIZE_4B          AXI AxSIZE value for 4-byte beats
//   RESP_OKAY        AXI xRESP value for a good response
//   MAX_BURST_BYTES  largest burst either master issues (64 beats x 4 B)
//   PAGE_BYTES       AXI 4 KB boundary a burst must not cross
package dma_2d_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_ADDR = 4'b0010,
        ST_DATA = 4'b0100,
        ST_RESP = 4'b1000
    } dma_state_t;

    localparam logic [1:0]  BURST_INCR      = 2'b01;
    localparam logic [2:0]  SIZE_4B         = 3'b010;
    localparam logic [1:0]  RESP_OKAY       = 2'b00;
    localparam logic [31:0] MAX_BURST_BYTES = 32'd256;
    localparam logic [31:0] PAGE_BYTES      = 32'd4096;

endpackage

// File: rtl/dma_burst_calc.sv
// Burst sizing for the 2D DMA masters (combinational).
//   i_cur_addr    address the next burst starts at (4-byte aligned)
//   i_line_bytes  bytes of the current line already transferred
//   i_width       line length in bytes (multiple of 4)
//   o_beats       beats in the next burst, 1..64
//   o_awlen       AxLEN for the next burst (o_beats - 1)
// The burst is the smallest of: the maximum burst, what is left of the line,
// and the distance to the next 4 KB page.
module dma_burst_calc
    import dma_2d_pkg::*;
(
    input  logic [31:0] i_cur_addr,
    input  logic [31:0] i_line_bytes,
    input  logic [31:0] i_width,
    output logic [7:0]  o_beats,
    output logic [7:0]  o_awlen
);

    logic [31:0] w_rem_line;
    logic [31:0] w_dist_4k;
    logic [31:0] w_bytes;

    assign w_rem_line = i_width - i_line_bytes;
    assign w_dist_4k  = ((i_cur_addr & ~(PAGE_BYTES - 32'd1)) + PAGE_BYTES) - i_cur_addr;

    always_comb begin
        w_bytes = MAX_BURST_BYTES;
        if (w_rem_line < w_bytes) begin
            w_bytes = w_rem_line;
        end
        if (w_dist_4k < w_bytes) begin
            w_bytes = w_dist_4k;
        end
    end

    // w_bytes never exceeds 256, so the beat count fits in 8 bits.
    assign o_beats = 8'(w_bytes >> 2);
    assign o_awlen = o_beats - 8'd1;

endmodule

// File: rtl/write_master_2d.sv
// AXI4 write master that drains a FWFT data FIFO into a 2D memory region:
// i_img_height lines of i_img_width bytes, line starts i_img_stride apart.
// One burst is outstanding at a time; bursts are at most 64 beats and never
// cross a 4 KB page.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   i_start                 job start pulse (only honoured when idle)
//   i_dst_addr/i_img_*      job geometry, sampled live, held for the job
//   o_write_done            level, set after the last B, cleared by start
//   o_busy                  not idle
//   o_error                 sticky bad-BRESP flag, cleared by start
//   i_fifo_empty/_data      FIFO status and head word
//   o_fifo_pop              pop strobe, equals the W handshake
//   m_axi_aw*/w*/b*         AXI4 write channels
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for i_start
// ADDR  | AWVALID high for the burst at r_cur_addr
// DATA  | streaming r_beats FIFO words onto W
// RESP  | waiting for the B response, then advance within the image
module write_master_2d
    import dma_2d_pkg::*;
#(
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32   // only 32 is supported
) (
    input  logic                            clk,
    input  logic                            reset_n,

    input  logic                            i_start,
    input  logic [31:0]                     i_dst_addr,
    input  logic [31:0]                     i_img_width,
    input  logic [31:0]                     i_img_height,
    input  logic [31:0]                     i_img_stride,
    output logic                            o_write_done,
    output logic                            o_busy,
    output logic                            o_error,

    input  logic                            i_fifo_empty,
    input  logic [31:0]                     i_fifo_data,
    output logic                            o_fifo_pop,

    output logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic [2:0]                      m_axi_awsize,
    output logic [1:0]                      m_axi_awburst,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wlast,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,

    input  logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready
);

    dma_state_t  r_state;
    dma_state_t  w_state_nxt;

    logic [31:0] r_cur_addr;
    logic [31:0] r_line_start;
    logic [31:0] r_line_bytes;
    logic [31:0] r_line_cnt;
    logic [7:0]  r_beats;
    logic [7:0]  r_beat_cnt;
    logic        r_done;
    logic        r_error;

    logic [7:0]  w_calc_beats;
    logic [7:0]  w_calc_awlen;
    logic [31:0] w_next_bytes;
    logic [31:0] w_next_line;
    logic        w_line_end;
    logic        w_last_line;
    logic        w_empty_job;
    logic        w_awvalid;
    logic        w_wvalid;
    logic        w_wlast;
    logic        w_bready;
    logic        w_w_hs;
    logic        w_unused;

    dma_burst_calc u_burst_calc (
        .i_cur_addr   (r_cur_addr),
        .i_line_bytes (r_line_bytes),
        .i_width      (i_img_width),
        .o_beats      (w_calc_beats),
        .o_awlen      (w_calc_awlen)
    );

    assign w_next_bytes = r_line_bytes + {22'd0, r_beats, 2'b00};
    assign w_next_line  = r_line_start + i_img_stride;
    assign w_line_end   = (w_next_bytes >= i_img_width);
    assign w_last_line  = (r_line_cnt == i_img_height - 32'd1);
    assign w_empty_job  = (i_img_width == 32'd0) || (i_img_height == 32'd0);
    assign w_w_hs       = w_wvalid && m_axi_wready;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_awvalid   = 1'b0;
        w_wvalid    = 1'b0;
        w_wlast     = 1'b0;
        w_bready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !w_empty_job) begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                w_awvalid = 1'b1;
                if (m_axi_awready) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_wvalid = !i_fifo_empty;
                w_wlast  = (r_beat_cnt == r_beats - 8'd1);
                if (w_wvalid && m_axi_wready && w_wlast) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_bready = 1'b1;
                if (m_axi_bvalid) begin
                    w_state_nxt = (w_line_end && w_last_line) ? ST_IDLE : ST_ADDR;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur_addr   <= 32'd0;
            r_line_start <= 32'd0;
            r_line_bytes <= 32'd0;
            r_line_cnt   <= 32'd0;
            r_beats      <= 8'd0;
            r_beat_cnt   <= 8'd0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_cur_addr   <= i_dst_addr;
                        r_line_start <= i_dst_addr;
                        r_line_bytes <= 32'd0;
                        r_line_cnt   <= 32'd0;
                        r_error      <= 1'b0;
                        // An empty job finishes immediately without leaving IDLE.
                        r_done       <= w_empty_job;
                    end
                end
                ST_ADDR: begin
                    if (m_axi_awready) begin
                        r_beats    <= w_calc_beats;
                        r_beat_cnt <= 8'd0;
                    end
                end
                ST_DATA: begin
                    if (w_w_hs) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != RESP_OKAY) begin
                            r_error <= 1'b1;
                        end
                        if (w_line_end) begin
                            r_line_start <= w_next_line;
                            r_cur_addr   <= w_next_line;
                            r_line_bytes <= 32'd0;
                            r_line_cnt   <= r_line_cnt + 32'd1;
                            if (w_last_line) begin
                                r_done <= 1'b1;
                            end
                        end else begin
                            r_cur_addr   <= r_cur_addr + {22'd0, r_beats, 2'b00};
                            r_line_bytes <= w_next_bytes;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------ outputs
    // Address and length are held at zero outside ADDR so the bus is quiet
    // while idle; inside ADDR they come from registers and are stable.
    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = w_awvalid ? C_M_AXI_ADDR_WIDTH'(r_cur_addr) : '0;
    assign m_axi_awlen   = w_awvalid ? w_calc_awlen : 8'd0;
    assign m_axi_awsize  = SIZE_4B;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awvalid = w_awvalid;

    assign m_axi_wdata   = C_M_AXI_DATA_WIDTH'(i_fifo_data);
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = w_wlast;
    assign m_axi_wvalid  = w_wvalid;
    assign o_fifo_pop    = w_w_hs;

    assign m_axi_bready  = w_bready;

    assign o_write_done  = r_done;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_error       = r_error;

    // BID carries nothing useful with a single outstanding burst.
    assign w_unused = ^m_axi_bid;

endmodule
